mult_u_seq_reschk: RTL and testbench

//   Parametrised unsigned WIDTH x WIDTH multiplier. Iterative shift-add datapath, one multiplier bit per cycle.

---
 rtl/mult_u_seq_reschk.sv | 164 ++++++++++++++++
 tb/tb_mult_u_seq_reschk.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_u_seq_reschk.sv
// mult_u_seq_reschk
//   Unsigned WIDTH x WIDTH sequential shift-add multiplier. It consumes one multiplier bit per
//   cycle. Each product is checked against a mod-3 residue predicted from the operands. The
//   result and its fault flag are returned over a valid/ready handshake.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          operand pair valid
//   in_ready   out  1          high only in idle; operand pair accepted on in_valid & in_ready
//   a          in   WIDTH      multiplicand
//   b          in   WIDTH      multiplier
//   out_valid  out  1          result valid (held until out_ready)
//   out_ready  in   1          consumer accepts result
//   prod       out  2*WIDTH    a*b
//   fault      out  1          residue mismatch for prod, qualified by out_valid
//   busy       out  1          high whenever not idle
//   fault_cnt  out  CNT_W      saturating count of results returned with fault=1

module mult_u_seq_reschk #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          CHECK_EN = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 fault,
  output logic                 busy,
  output logic [CNT_W-1:0]     fault_cnt
);

  localparam int unsigned    CntBits = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntBits-1:0] CntLast = CntBits'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  // Adds two residues already in 0..2.
  function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // 2^i mod 3 alternates 1,2,1,2..., so the residue is a weighted bit sum; no divider.
  function automatic logic [1:0] mod3_of(input logic [2*WIDTH-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (v[i]) r = mod3_add(r, (i % 2 == 0) ? 2'd1 : 2'd2);
    end
    return r;
  endfunction

  // Product of two residues in 0..2 is at most 4, so one conditional subtract suffices.
  function automatic logic [1:0] mod3_mul(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] p;
    p = {2'b00, x} * {2'b00, y};
    if (p >= 4'd3) p = p - 4'd3;
    return p[1:0];
  endfunction

  state_e                 r_state;
  state_e                 w_state_d;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [2*WIDTH:0]       r_acc;
  logic [CntBits-1:0]     r_cnt;
  logic [1:0]             r_rp;
  logic [2*WIDTH-1:0]     r_prod;
  logic                   r_fault;
  logic [CNT_W-1:0]       r_fault_cnt;

  logic [WIDTH:0]         w_sum;
  logic [2*WIDTH:0]       w_acc_add;
  logic [2*WIDTH:0]       w_acc_shift;
  logic [2*WIDTH-1:0]     w_prod_chk;
  logic [1:0]             w_prod_res;
  logic [1:0]             w_rp;

  // After the shift the top acc bit is always 0, so the upper half plus A fits in WIDTH+1 bits.
  assign w_sum       = r_acc[2*WIDTH:WIDTH] + {1'b0, r_a};
  assign w_acc_add   = r_b[0] ? {w_sum, r_acc[WIDTH-1:0]} : r_acc;
  assign w_acc_shift = w_acc_add >> 1;

  // Single tap of the finished product; both the result register and the checker read it.
  assign w_prod_chk  = r_acc[2*WIDTH-1:0];
  assign w_prod_res  = mod3_of(w_prod_chk);
  assign w_rp        = mod3_mul(mod3_of({{WIDTH{1'b0}}, a}), mod3_of({{WIDTH{1'b0}}, b}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_d = StRun;
      StRun:   if (r_cnt == CntLast) w_state_d = StCheck;
      StCheck: w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rp        <= '0;
      r_prod      <= '0;
      r_fault     <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
            r_rp  <= w_rp;
          end
        end
        StRun: begin
          r_acc <= w_acc_shift;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
        end
        StCheck: begin
          r_prod  <= w_prod_chk;
          r_fault <= CHECK_EN && (w_prod_res != r_rp);
        end
        StDone: begin
          if (out_ready && r_fault && !(&r_fault_cnt)) begin
            r_fault_cnt <= r_fault_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign prod      = r_prod;
  assign fault     = r_fault;
  assign fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_mult_u_seq_reschk.sv
// Bench for mult_u_seq_reschk: a 4-bit instance (CNT_W=2, checking on) and an 8-bit instance
// (checking off). Stimulus pushes expected results into per-instance queues; monitors pop and
// compare on every output handshake.

module tb_mult_u_seq_reschk;

  typedef struct packed {
    logic [15:0] prod;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-bit instance
  logic       u4_in_valid, u4_in_ready, u4_out_valid, u4_out_ready, u4_fault, u4_busy;
  logic [3:0] u4_a, u4_b;
  logic [7:0] u4_prod;
  logic [1:0] u4_fault_cnt;

  // 8-bit instance
  logic        u8_in_valid, u8_in_ready, u8_out_valid, u8_out_ready, u8_fault, u8_busy;
  logic [7:0]  u8_a, u8_b;
  logic [15:0] u8_prod;
  logic [7:0]  u8_fault_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q4[$];
  exp_t q8[$];

  mult_u_seq_reschk #(.WIDTH(4), .CHECK_EN(1'b1), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(u4_in_valid), .in_ready(u4_in_ready), .a(u4_a), .b(u4_b),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready), .prod(u4_prod), .fault(u4_fault),
    .busy(u4_busy), .fault_cnt(u4_fault_cnt)
  );

  mult_u_seq_reschk #(.WIDTH(8), .CHECK_EN(1'b0), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(u8_in_valid), .in_ready(u8_in_ready), .a(u8_a), .b(u8_b),
    .out_valid(u8_out_valid), .out_ready(u8_out_ready), .prod(u8_prod), .fault(u8_fault),
    .busy(u8_busy), .fault_cnt(u8_fault_cnt)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no event within bound, required event", nm);
  endtask

  // Monitors: one pop per handshake; an output with nothing expected is an error.
  always @(negedge clk) begin
    if (u4_out_valid && u4_out_ready) begin
      if (q4.size() == 0) begin
        timeout("u4 unexpected result (queue empty)");
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("u4 prod", u4_prod, e.prod);
        chk("u4 fault", u4_fault, e.fault);
      end
    end
  end

  always @(negedge clk) begin
    if (u8_out_valid && u8_out_ready) begin
      if (q8.size() == 0) begin
        timeout("u8 unexpected result (queue empty)");
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("u8 prod", u8_prod, e.prod);
        chk("u8 fault", u8_fault, e.fault);
      end
    end
  end

  // Raises in_valid and returns #1 after the accepting edge; in_valid is left high.
  // n = number of edges spent offering, including the accepting one.
  task automatic offer4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] ep,
                        input logic ef, input bit push, output int n);
    bit got;
    u4_a = a;
    u4_b = b;
    u4_in_valid = 1'b1;
    if (push) q4.push_back('{prod: {8'd0, ep}, fault: ef});
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = u4_in_ready;
      @(posedge clk);
      n++;
    end
    if (!got) timeout("u4 accept");
    #1;
  endtask

  task automatic offer8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ep,
                        input logic ef, output int n);
    bit got;
    u8_a = a;
    u8_b = b;
    u8_in_valid = 1'b1;
    q8.push_back('{prod: ep, fault: ef});
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = u8_in_ready;
      @(posedge clk);
      n++;
    end
    if (!got) timeout("u8 accept");
    #1;
  endtask

  // Called #1 after the accepting edge; counts edges (accepting edge = 1) until out_valid.
  // Returns at the negedge where out_valid is first seen.
  task automatic wait_valid4(output int n);
    n = 1;
    @(negedge clk);
    while (!u4_out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!u4_out_valid) timeout("u4 out_valid");
  endtask

  task automatic wait_valid8(output int n);
    n = 1;
    @(negedge clk);
    while (!u8_out_valid && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!u8_out_valid) timeout("u8 out_valid");
  endtask

  // Directed vectors for the 4-bit instance: {a, b, a*b}
  logic [3:0] va[4] = '{4'd3, 4'd1, 4'd12, 4'd15};
  logic [3:0] vb[4] = '{4'd5, 4'd15, 4'd12, 4'd0};
  logic [7:0] vp[4] = '{8'd15, 8'd15, 8'd144, 8'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nw;
    bit stable;
    rst = 1'b1;
    u4_in_valid = 1'b0; u4_a = '0; u4_b = '0; u4_out_ready = 1'b1;
    u8_in_valid = 1'b0; u8_a = '0; u8_b = '0; u8_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst in_ready", u4_in_ready, 1);
    chk("rst out_valid", u4_out_valid, 0);
    chk("rst prod", u4_prod, 0);
    chk("rst fault", u4_fault, 0);
    chk("rst busy", u4_busy, 0);
    chk("rst fault_cnt", u4_fault_cnt, 0);
    @(posedge clk); #1;

    // T1: 15*15, out_valid on the 6th edge counting the accepting one
    offer4(4'd15, 4'd15, 8'd225, 1'b0, 1'b1, nw);
    u4_in_valid = 1'b0;
    wait_valid4(n);
    chk("T1 latency", n, 6);
    @(posedge clk); #1;

    // T2: back-to-back; second pair held through the whole first op (WIDTH+3 edges)
    offer4(4'd13, 4'd11, 8'd143, 1'b0, 1'b1, nw);
    chk("T2 busy after accept", u4_busy, 1);
    offer4(4'd0, 4'd9, 8'd0, 1'b0, 1'b1, nw);
    chk("T2 second accept edges", nw, 7);
    u4_in_valid = 1'b0;
    wait_valid4(n);
    chk("T2 latency x*0", n, 6);
    @(posedge clk); #1;

    foreach (va[i]) begin
      offer4(va[i], vb[i], vp[i], 1'b0, 1'b1, nw);
      u4_in_valid = 1'b0;
      wait_valid4(n);
      @(posedge clk); #1;
    end

    // T3: backpressure for 10 clocks
    u4_out_ready = 1'b0;
    offer4(4'd10, 4'd12, 8'd120, 1'b0, 1'b1, nw);
    u4_in_valid = 1'b0;
    wait_valid4(n);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (u4_prod !== 8'd120 || u4_fault !== 1'b0 || u4_in_ready !== 1'b0 ||
          u4_out_valid !== 1'b1) stable = 1'b0;
    end
    chk("T3 held under backpressure", stable, 1);
    @(posedge clk); #1 u4_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("T3 in_ready after handshake", u4_in_ready, 1);
    chk("T3 out_valid after handshake", u4_out_valid, 0);
    @(posedge clk); #1;

    // T4: corrupt the checked product to 43 (42 | 1); 7*6 predicts residue 0, 43 mod 3 = 1
    force u_dut4.w_prod_chk = 8'd43;
    for (int k = 1; k <= 4; k++) begin
      offer4(4'd7, 4'd6, 8'd43, 1'b1, 1'b1, nw);
      u4_in_valid = 1'b0;
      wait_valid4(n);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("T4 fault_cnt after fault %0d", k), u4_fault_cnt, (k < 3) ? k : 3);
      @(posedge clk); #1;
    end
    release u_dut4.w_prod_chk;

    // T5: reset during the 2nd RUN cycle discards the operation
    offer4(4'd9, 4'd9, 8'd81, 1'b0, 1'b0, nw);
    u4_in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("T5 in_ready after rst", u4_in_ready, 1);
    chk("T5 out_valid after rst", u4_out_valid, 0);
    chk("T5 busy after rst", u4_busy, 0);
    chk("T5 fault_cnt after rst", u4_fault_cnt, 0);
    @(posedge clk); #1;
    offer4(4'd9, 4'd9, 8'd81, 1'b0, 1'b1, nw);
    u4_in_valid = 1'b0;
    wait_valid4(n);
    chk("T5 latency fresh op", n, 6);
    @(posedge clk); #1;

    // T6: 8-bit instance, checking disabled
    offer8(8'd255, 8'd255, 16'd65025, 1'b0, nw);
    u8_in_valid = 1'b0;
    wait_valid8(n);
    chk("T6 latency 8-bit", n, 10);
    @(posedge clk); #1;
    offer8(8'd200, 8'd3, 16'd600, 1'b0, nw);
    u8_in_valid = 1'b0;
    wait_valid8(n);
    @(posedge clk); #1;
    force u_dut8.w_prod_chk = 16'd43;
    offer8(8'd7, 8'd6, 16'd43, 1'b0, nw);
    u8_in_valid = 1'b0;
    wait_valid8(n);
    @(posedge clk); #1;
    release u_dut8.w_prod_chk;
    @(negedge clk);
    chk("T6 fault_cnt with check off", u8_fault_cnt, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("u4 results drained", q4.size(), 0);
    chk("u8 results drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
